// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;
  localparam int ERR_W     = 8;
endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for one TDM frame: clear > load1 > inc, wraps after NCH-1.
module tdm_slot_cnt #(
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clear,
  output logic [SW-1:0] slot,
  output logic          last
);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

  assign last = (slot == LAST_SLOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      slot <= '0;
    else if (clear)  slot <= '0;
    else if (load1)  slot <= SW'(1);
    else if (inc)    slot <= last ? '0 : slot + 1'b1;
  end
endmodule

// File: rtl/tdm_demux_4.sv
// TDM frame demultiplexer with fsync alignment; TDM_DEMUX_ERRCNT_EN enables
// the saturating misaligned-fsync counter on err_cnt.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   fsync,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic                   frame_valid,
  output logic                   locked,
  output logic                   sync_err,
  output logic [ERR_W-1:0]       err_cnt
);
  localparam int SW = $clog2(NCH);

  state_e                    state;
  logic [SW-1:0]             slot;
  logic                      last;
  logic [NCH-1:0][WIDTH-1:0] shadow, frame_nxt, dout_q;
  logic                      acc_sync, misalign, inc, load1, clear;

  assign acc_sync = din_valid & fsync;
  assign misalign = acc_sync & (state == LOCKED) & (slot != '0);
  // Frame start in HUNT and a resync in LOCKED both restart at slot 1.
  assign load1    = (state == HUNT) ? acc_sync : misalign;
  assign inc      = din_valid & (state == LOCKED) & ~misalign;
  assign clear    = (state == HUNT) & ~load1;

  tdm_slot_cnt #(.NCH(NCH), .SW(SW)) u_slot (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load1(load1), .clear(clear),
    .slot(slot), .last(last)
  );

  always_comb begin
    frame_nxt          = shadow;
    frame_nxt[NCH-1]   = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      locked      <= 1'b0;
      shadow      <= '0;
      dout_q      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= misalign;
      if (load1) begin
        shadow[0] <= din;
        state     <= LOCKED;
        locked    <= 1'b1;
      end else if (inc) begin
        shadow[slot] <= din;
      end
      if (inc && last) begin
        dout_q      <= frame_nxt;
        frame_valid <= 1'b1;
      end
    end
  end

  assign dout = dout_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERR_W-1:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= '0;
    else if (misalign && ~&err_q)     err_q <= err_q + 1'b1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4 (default WIDTH=8, NCH=4).
module tb_tdm_demux_4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        fsync = 1'b0;
  logic [31:0] dout;
  logic        frame_valid, locked, sync_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  logic serr_seen;

`ifdef TDM_DEMUX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  tdm_demux_4 dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
    .dout(dout), .frame_valid(frame_valid), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one accepted word, return 1 time unit after the capturing edge.
  task automatic word(input logic [7:0] d, input logic fs);
    din = d; din_valid = 1'b1; fsync = fs;
    @(posedge clk); #1;
    din_valid = 1'b0; fsync = 1'b0;
    serr_seen |= sync_err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      serr_seen |= sync_err;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  initial begin
    serr_seen = 1'b0;
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_serr", sync_err, 0);
    chk("rst_errcnt", err_cnt, 0);
    do_reset();

    // Non-fsync words in HUNT are dropped
    word(8'hAA, 0); word(8'hBB, 0);
    chk("hunt_locked", locked, 0);
    chk("hunt_fv", frame_valid, 0);
    chk("hunt_dout", dout, 0);

    // Fsync with din_valid=0 is ignored
    fsync = 1'b1; idle(1); fsync = 1'b0;
    chk("fsync_novalid_locked", locked, 0);

    // Back-to-back frame
    word(8'h11, 1);
    chk("b2b_locked", locked, 1);
    word(8'h22, 0); word(8'h33, 0);
    chk("b2b_fv_early", frame_valid, 0);
    word(8'h44, 0);
    chk("b2b_fv", frame_valid, 1);
    chk("b2b_dout", dout, 32'h44332211);
    idle(1);
    chk("b2b_fv_pulse", frame_valid, 0);
    chk("b2b_dout_hold", dout, 32'h44332211);

    // Gapped frame from a fresh reset
    do_reset();
    serr_seen = 1'b0;
    word(8'h11, 1); idle(3);
    word(8'h22, 0); idle(3);
    word(8'h33, 0); idle(3);
    chk("gap_dout_before", dout, 0);
    word(8'h44, 0);
    chk("gap_fv", frame_valid, 1);
    chk("gap_dout", dout, 32'h44332211);
    chk("gap_no_serr", serr_seen, 0);

    // Misaligned fsync: partial frame dropped, resync at channel 0
    word(8'h01, 1);
    chk("align_serr", sync_err, 0);
    word(8'h02, 0);
    word(8'h10, 1);
    chk("mis_serr", sync_err, 1);
    chk("mis_fv", frame_valid, 0);
    chk("mis_dout_held", dout, 32'h44332211);
    chk("mis_locked", locked, 1);
    word(8'h20, 0);
    chk("mis_serr_pulse", sync_err, 0);
    word(8'h30, 0);
    chk("mis_dout_still", dout, 32'h44332211);
    word(8'h40, 0);
    chk("mis_fv_new", frame_valid, 1);
    chk("mis_dout_new", dout, 32'h40302010);
    chk("mis_errcnt", err_cnt, ERRCNT ? 1 : 0);

    // Aligned frame right after wrap: no error
    word(8'hA1, 1);
    chk("wrap_serr", sync_err, 0);
    word(8'hB2, 0); word(8'hC3, 0); word(8'hD4, 0);
    chk("wrap_dout", dout, 32'hD4C3B2A1);

    // Reset mid-frame
    word(8'h99, 1); word(8'h9A, 0);
    rst_n = 1'b0; #2;
    chk("midrst_dout", dout, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_errcnt", err_cnt, 0);
    #10 rst_n = 1'b1;
    idle(1);
    word(8'h77, 0);
    chk("midrst_hunt", locked, 0);
    word(8'h55, 1); word(8'h66, 0); word(8'h77, 0); word(8'h88, 0);
    chk("midrst_fv", frame_valid, 1);
    chk("midrst_dout", dout, 32'h88776655);

    // Error counter saturation
    word(8'h00, 1);
    for (int i = 0; i < 254; i++) word(8'h00, 1);
    chk("sat_254", err_cnt, ERRCNT ? 254 : 0);
    word(8'h00, 1);
    chk("sat_255", err_cnt, ERRCNT ? 255 : 0);
    for (int i = 0; i < 45; i++) word(8'h00, 1);
    chk("sat_hold", err_cnt, ERRCNT ? 255 : 0);
    chk("sat_serr", sync_err, 1);
    chk("sat_dout_held", dout, 32'h88776655);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdm_demux_4.md
TDM_DEMUX_4 -- requirements
Module: tdm_demux_4

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one channel word.
REQ-002 Parameter NCH, default 4: channels per frame; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  TDM word for the current slot.
REQ-006 din_valid  input  1  din is valid this cycle; a word is accepted only when din_valid=1.
REQ-007 fsync  input  1  frame start; qualified by din_valid; marks din as channel 0.
REQ-008 dout  output  NCH*WIDTH  last complete frame; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 frame_valid  output  1  single-cycle pulse on each dout update.
REQ-010 locked  output  1  high while in state LOCKED.
REQ-011 sync_err  output  1  single-cycle pulse on a misaligned fsync.
REQ-012 err_cnt  output  8  count of misaligned fsync events; see Configuration.

Function
REQ-013 The block SHALL have two states: HUNT and LOCKED, plus a slot counter of width clog2(NCH).
REQ-014 In HUNT, accepted words with fsync=0 SHALL be discarded.
REQ-015 In HUNT, an accepted word with fsync=1 SHALL be stored as channel 0, set slot to 1, and move the block to LOCKED.
REQ-016 In LOCKED, each accepted word SHALL be stored in the shadow register for the current slot, and slot SHALL increment.
REQ-017 When slot = NCH-1 and the word is accepted, slot SHALL wrap to 0, and on the next edge dout SHALL load the shadow registers plus that word atomically, with frame_valid=1 for exactly that cycle.
REQ-018 Latency: dout and frame_valid SHALL update 1 cycle after the last-slot word is accepted.
REQ-019 In LOCKED, an accepted word with fsync=1 and slot=0 is normal alignment and SHALL cause no error.
REQ-020 In LOCKED, an accepted word with fsync=1 and slot≠0 SHALL raise sync_err for one cycle, discard the partial frame (dout unchanged, no frame_valid), store the word as channel 0, and set slot to 1; the state SHALL remain LOCKED.
REQ-021 fsync with din_valid=0 SHALL be ignored in all states.
REQ-022 din_valid=0 cycles SHALL hold slot, state and shadow registers unchanged; gaps are legal anywhere in a frame.
REQ-023 dout SHALL hold its value between frames, and SHALL NOT be modified by partial frames.

Reset
REQ-024 rst_n=0 SHALL immediately clear all registers: state=HUNT, slot=0, shadow=0, dout=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait in HUNT for fsync.
REQ-026 Reset deassertion is assumed synchronised externally to clk.

Configuration
REQ-027 Macro TDM_DEMUX_ERRCNT_EN defined: err_cnt SHALL increment on each sync_err pulse and saturate at 255; it is cleared only by reset.
REQ-028 Macro TDM_DEMUX_ERRCNT_EN undefined: err_cnt SHALL be tied to 0, with no counter logic; the port SHALL remain present.

Structure
REQ-029 Shared package tdm_pkg SHALL hold the state enum (HUNT, LOCKED), the default WIDTH/NCH constants and the err_cnt width constant.
REQ-030 Slot counting and wrap SHALL live in sub-module tdm_slot_cnt (inputs: inc, load1, clear; output: slot, last); the FSM and datapath SHALL remain in tdm_demux_4.

Verification
REQ-031 Reset, then fsync+din=0x11, followed by 0x22, 0x33, 0x44 on back-to-back cycles -> one cycle later dout=0x44332211, frame_valid pulses once, locked=1.
REQ-032 Words 0xAA, 0xBB with fsync=0 while in HUNT -> no frame_valid, locked=0, dout=0.
REQ-033 Frame 0x11..0x44 with din_valid=0 gaps of 3 cycles between words -> dout=0x44332211 one cycle after 0x44 is accepted; no sync_err.
REQ-034 In LOCKED, send fsync+0x01, 0x02, then fsync+0x10, 0x20, 0x30, 0x40 -> sync_err pulses on the third word, and the next dout=0x40302010; the previous dout is retained until then; err_cnt=1 with the macro defined, 0 without.
REQ-035 Assert rst_n=0 after slot 2 of a frame, release, then send a full frame 0x55,0x66,0x77,0x88 with fsync on 0x55 -> dout=0x88776655, with no leftover data from the aborted frame.
REQ-036 With the macro defined, 300 misaligned fsync events -> err_cnt saturates at 255.
